// File: rtl/storage_spi_pkg.sv
// Shared opcodes, FSM state encoding and sizing constants for the SPI flash responder.
package storage_spi_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WAKE = 8'hAB;

  localparam int unsigned SCK_OVERSAMPLE_MIN = 8;
  localparam int unsigned SPI_ADDR_BITS      = 24;
  localparam int unsigned CMD_BITS           = 8;
  localparam int unsigned BIT_CNT_W          = 5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    STATUS,
    IGNORE
  } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the SPI pins into clk and produces registered edge strobes
// aligned with the synchronised level of each pin.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic cs_n_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_q;

  // cs_n chain resets low so a select already held low at reset release is never mistaken for idle
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      cs_n_s    <= 1'b0;
      sck_rise  <= 1'b0;
      sck_fall  <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_n_s    <= cs_sync[SYNC_STAGES-1];
      cs_fall   <= cs_n_s & ~cs_sync[SYNC_STAGES-1];
      cs_rise   <= ~cs_n_s & cs_sync[SYNC_STAGES-1];
      sck_q     <= sck_sync[SYNC_STAGES-1];
      sck_rise  <= ~sck_q & sck_sync[SYNC_STAGES-1];
      sck_fall  <= sck_q & ~sck_sync[SYNC_STAGES-1];
      mosi_s    <= mosi_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target serving READ / RDSR / WAKE from a byte-wide memory,
// with all SPI pins oversampled in the clk domain.
module spi_flash_responder
  import storage_spi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  logic cs_n_s, sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk     (clk),
    .rst     (rst),
    .spi_cs_n(spi_cs_n),
    .spi_sck (spi_sck),
    .spi_mosi(spi_mosi),
    .cs_n_s  (cs_n_s),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .cs_fall (cs_fall),
    .cs_rise (cs_rise),
    .mosi_s  (mosi_s)
  );

  spi_state_e           state_q, state_d;
  logic                 armed_q, armed_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [22:0]          shreg_q, shreg_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic [7:0]           nxt_byte_q, nxt_byte_d;
  logic                 seen_rise_q, seen_rise_d;
  logic                 rd_dly_q, rd_dly_d;
  logic                 miso_d, rd_en_d, busy_d, cmd_err_d;
  logic [ADDR_W-1:0]    mem_addr_d;
  logic [23:0]          shift_in;
  logic [7:0]           opcode;

  assign shift_in = {shreg_q, mosi_s};
  assign opcode   = shift_in[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      addr_q      <= '0;
      tx_byte_q   <= '0;
      nxt_byte_q  <= '0;
      seen_rise_q <= 1'b0;
      rd_dly_q    <= 1'b0;
      spi_miso    <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      addr_q      <= addr_d;
      tx_byte_q   <= tx_byte_d;
      nxt_byte_q  <= nxt_byte_d;
      seen_rise_q <= seen_rise_d;
      rd_dly_q    <= rd_dly_d;
      spi_miso    <= miso_d;
      mem_rd_en   <= rd_en_d;
      mem_addr    <= mem_addr_d;
      busy        <= busy_d;
      cmd_err     <= cmd_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | cs_n_s;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    addr_d      = addr_q;
    tx_byte_d   = tx_byte_q;
    nxt_byte_d  = nxt_byte_q;
    seen_rise_d = seen_rise_q;
    rd_dly_d    = mem_rd_en;
    miso_d      = spi_miso;
    rd_en_d     = 1'b0;
    mem_addr_d  = mem_addr;
    cmd_err_d   = 1'b0;

    // Deselect wins over any same-cycle sck edge and drops in-flight reads
    if (cs_n_s || cs_rise) begin
      state_d     = IDLE;
      miso_d      = 1'b0;
      rd_dly_d    = 1'b0;
      bit_cnt_d   = '0;
      seen_rise_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q && cs_fall) begin
            state_d   = CMD;
            bit_cnt_d = '0;
          end
        end

        CMD: begin
          miso_d = 1'b0;
          if (sck_rise) begin
            shreg_d   = shift_in[22:0];
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(CMD_BITS - 1)) begin
              bit_cnt_d = '0;
              case (opcode)
                OP_READ: state_d = ADDR;
                OP_RDSR: state_d = STATUS;
                OP_WAKE: state_d = IGNORE;
                default: begin
                  state_d   = IGNORE;
                  cmd_err_d = 1'b1;
                end
              endcase
            end
          end
        end

        ADDR: begin
          if (rd_dly_q) begin
            tx_byte_d   = mem_rdata;
            miso_d      = mem_rdata[7];
            state_d     = DATA;
            bit_cnt_d   = '0;
            seen_rise_d = 1'b0;
          end else if (sck_rise && bit_cnt_q < BIT_CNT_W'(SPI_ADDR_BITS)) begin
            shreg_d   = shift_in[22:0];
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(SPI_ADDR_BITS - 1)) begin
              addr_d     = ADDR_W'(shift_in);
              mem_addr_d = ADDR_W'(shift_in);
              rd_en_d    = 1'b1;
            end
          end
        end

        DATA: begin
          if (rd_dly_q) nxt_byte_d = mem_rdata;
          // bit_cnt[2:0] counts rises within the byte; 0 means bit 7 is being sampled
          if (sck_rise) begin
            seen_rise_d = 1'b1;
            bit_cnt_d   = {2'b00, 3'(bit_cnt_q[2:0] + 3'd1)};
            if (bit_cnt_q[2:0] == 3'd0) begin
              addr_d     = addr_q + ADDR_W'(1);
              mem_addr_d = addr_q + ADDR_W'(1);
              rd_en_d    = 1'b1;
            end
          end else if (sck_fall && seen_rise_q) begin
            if (bit_cnt_q[2:0] == 3'd0) begin
              tx_byte_d = nxt_byte_q;
              miso_d    = nxt_byte_q[7];
            end else begin
              tx_byte_d = {tx_byte_q[6:0], tx_byte_q[7]};
              miso_d    = tx_byte_q[6];
            end
          end
        end

        STATUS:  miso_d = 1'b0;
        IGNORE:  miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed + randomised bench: an SPI mode-0 master drives the responder and
// checks returned bytes, memory reads and status strobes against a flash model.
module tb_spi_flash_responder;
  import storage_spi_pkg::*;

  localparam int unsigned ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_cs_n, spi_sck, spi_mosi, spi_miso;
  logic              mem_rd_en, busy, cmd_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  logic [23:0] rd_log[$];
  logic [7:0]  mem_ovr[int];

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  // Flash contents: explicit overrides, otherwise a fixed hash of the address
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_byte(mem_addr);

  always @(negedge clk) begin
    if (mem_rd_en) rd_log.push_back(mem_addr);
    if (cmd_err) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mode-0 master: drive mosi after fall, sample miso at rise; leaves cs_n low
  task automatic spi_xfer(input logic [7:0] tx[$], input int nbits, input int hp,
                          output logic [7:0] rx[$]);
    logic [7:0] cur;
    cur = 8'h00;
    rx = {};
    spi_cs_n = 1'b0;
    repeat (hp) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i / 8 < tx.size()) ? tx[i/8][7-(i%8)] : 1'($urandom);
      repeat (hp) @(negedge clk);
      cur = {cur[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (hp) @(negedge clk);
      spi_sck = 1'b0;
      if (i % 8 == 7) rx.push_back(cur);
    end
    repeat (hp) @(negedge clk);
  endtask

  task automatic cs_end();
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_read(input logic [23:0] a, input int n, input int hp,
                         output logic [7:0] data[$]);
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    txq = {OP_READ, a[23:16], a[15:8], a[7:0]};
    spi_xfer(txq, 32 + 8 * n, hp, rxq);
    data = {};
    for (int i = 4; i < rxq.size(); i++) data.push_back(rxq[i]);
  endtask

  // Each byte whose bit 7 is sampled prefetches the following address
  task automatic check_read(input string tag, input logic [23:0] a, input int n,
                            input int hp, output logic [7:0] data[$]);
    logic [23:0] ea;
    rd_log.delete();
    do_read(a, n, hp, data);
    cs_end();
    chk({tag, " rd_cnt"}, 32'(rd_log.size()), 32'(n + 1));
    for (int i = 0; i < n; i++) begin
      ea = a + 24'(i);
      chk($sformatf("%s byte%0d", tag, i), 32'(data[i]), 32'(mem_byte(ea)));
    end
    for (int i = 0; i <= n && i < rd_log.size(); i++) begin
      ea = a + 24'(i);
      chk($sformatf("%s rd_addr%0d", tag, i), 32'(rd_log[i]), 32'(ea));
    end
  endtask

  task automatic check_opcode(input string tag, input logic [7:0] op, input int hp);
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    rd_log.delete();
    err_cnt = 0;
    txq = {op};
    spi_xfer(txq, 8 + 32, hp, rxq);
    chk({tag, " busy_in"}, 32'(busy), 32'(1));
    cs_end();
    chk({tag, " busy_out"}, 32'(busy), 32'(0));
    chk({tag, " cmd_err"}, 32'(err_cnt), (op == OP_WAKE || op == OP_RDSR) ? 32'(0) : 32'(1));
    chk({tag, " no_rd"}, 32'(rd_log.size()), 32'(0));
    for (int i = 1; i < rxq.size(); i++)
      chk($sformatf("%s miso%0d", tag, i), 32'(rxq[i]), 32'(0));
  endtask

  initial begin
    logic [7:0] d4[$];
    logic [7:0] d16[$];
    logic [7:0] dq[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] empty_q[$];
    logic [7:0] op;

    rst = 1'b1;
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst miso", 32'(spi_miso), 32'(0));
    chk("rst rd_en", 32'(mem_rd_en), 32'(0));
    chk("rst addr", 32'(mem_addr), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst cmd_err", 32'(cmd_err), 32'(0));
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Test 1 / Test 7: same READ at 8x and 32x oversampling
    mem_ovr[16] = 8'hA5;
    mem_ovr[17] = 8'h3C;
    mem_ovr[18] = 8'h00;
    mem_ovr[19] = 8'hFF;
    check_read("t1_hp4", 24'h000010, 4, 4, d4);
    check_read("t1_hp16", 24'h000010, 4, 16, d16);
    for (int i = 0; i < 4; i++) chk($sformatf("t7 stream%0d", i), 32'(d4[i]), 32'(d16[i]));

    // Test 2: address wrap
    check_read("t2_hp4", 24'hFFFFFF, 2, 4, dq);
    check_read("t2_hp16", 24'hFFFFFF, 2, 16, dq);

    // Test 3 / 4: unsupported opcode, status read, wake
    check_opcode("t3_9F", 8'h9F, 4);
    check_opcode("t4_rdsr", OP_RDSR, 4);
    check_opcode("t4_rdsr16", OP_RDSR, 16);
    check_opcode("wake", OP_WAKE, 5);

    // Test 5: abort inside address phase, then a fresh READ
    rd_log.delete();
    txq = {OP_READ, 8'h00, 8'h12};
    spi_xfer(txq, 8 + 12, 4, rxq);
    cs_end();
    chk("t5 aborted_no_rd", 32'(rd_log.size()), 32'(0));
    check_read("t5", 24'h000004, 1, 4, dq);

    // Test 6: reset mid-DATA with cs_n held low
    txq = {OP_READ, 8'h00, 8'h00, 8'h08};
    spi_xfer(txq, 32 + 12, 4, rxq);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd_log.delete();
    spi_xfer(empty_q, 16, 4, rxq);
    chk("t6 busy_held", 32'(busy), 32'(0));
    chk("t6 no_rd", 32'(rd_log.size()), 32'(0));
    chk("t6 miso0", 32'(rxq[0]), 32'(0));
    chk("t6 miso1", 32'(rxq[1]), 32'(0));
    cs_end();
    check_read("t6_after", 24'h000008, 2, 4, dq);

    // Randomised READs and opcodes
    for (int k = 0; k < 6; k++) begin
      mem_ovr[int'($urandom_range(0, 255))] = 8'($urandom);
      check_read($sformatf("rnd%0d", k), 24'($urandom), int'($urandom_range(1, 4)),
                 int'($urandom_range(4, 12)), dq);
    end
    for (int k = 0; k < 4; k++) begin
      op = 8'($urandom);
      if (op == OP_READ) op = 8'h9F;
      check_opcode($sformatf("rnd_op%0d", k), op, int'($urandom_range(4, 8)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
